// File: rtl/agc_dsp_multi.sv
// Multi-lane AGC scale/offset stage with saturation, window-synchronous settings commit
// and per-window saturation counters. Define AGC_DSP_MULTI_ROUND_EN for round-half-up.
module agc_dsp_multi #(
   parameter int NSAMP       = 8,
   parameter int DAT_BITS    = 12,
   parameter int Q_DAT       = 0,
   parameter int OFFSET_BITS = 12,
   parameter int Q_OFFSET    = 8,
   parameter int Q_SCALE     = 12,
   parameter int SCALE_IN    = 5,
   parameter int NFRAC_OUT   = 2,
   parameter int NBITS       = 5,
   parameter int WINDOW_LOG2 = 16,
   parameter int CNT_BITS    = 24
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NSAMP*DAT_BITS-1:0]    dat_i,
   input  logic [16:0]                  scale_i,
   input  logic [OFFSET_BITS-1:0]       offset_i,
   input  logic                         ce_scale_i,
   input  logic                         ce_offset_i,
   input  logic                         apply_i,
   output logic [NSAMP*NBITS-1:0]       out_o,
   output logic [NSAMP*(NBITS-1)-1:0]   abs_o,
   output logic [NSAMP-1:0]             gt_o,
   output logic [NSAMP-1:0]             lt_o,
   output logic                         apply_pending_o,
   output logic                         apply_done_o,
   output logic [CNT_BITS-1:0]          sat_hi_cnt_o,
   output logic [CNT_BITS-1:0]          sat_lo_cnt_o,
   output logic                         cnt_valid_o
);
   localparam int Q_SUM     = (Q_DAT > Q_OFFSET) ? Q_DAT : Q_OFFSET;
   localparam int LSB       = Q_SUM + Q_SCALE + SCALE_IN - NFRAC_OUT;
   localparam int SUM_BITS  = 27;
   localparam int PROD_BITS = SUM_BITS + 18;
   localparam int DSH       = Q_SUM - Q_DAT;
   localparam int OSH       = Q_SUM - Q_OFFSET;
   localparam logic [16:0] UNITY = 17'(1) << Q_SCALE;
   localparam logic signed [PROD_BITS-1:0] QMAX = PROD_BITS'((1 << (NBITS-1)) - 1);
   localparam logic signed [PROD_BITS-1:0] QMIN = -PROD_BITS'(1 << (NBITS-1));
   localparam logic [NBITS-1:0]   MINOUT = {1'b1, {(NBITS-1){1'b0}}};
   localparam logic [NBITS-2:0]   MAXABS = '1;
`ifdef AGC_DSP_MULTI_ROUND_EN
   localparam logic signed [PROD_BITS-1:0] ROUND_C = PROD_BITS'(1) << (LSB-1);
`else
   localparam logic signed [PROD_BITS-1:0] ROUND_C = '0;
`endif

   typedef enum logic [1:0] {IDLE = 2'd0, PENDING = 2'd1, COMMIT = 2'd2} applyState_e;

   applyState_e state_q, state_d;
   logic [WINDOW_LOG2-1:0] winCnt_q;
   logic winEnd;

   logic [16:0]                   scaleStg_q, scaleAct_q, scaleD_q, scaleA_q;
   logic signed [OFFSET_BITS-1:0] offsetStg_q, offsetAct_q, offsetD_q;
   logic signed [DAT_BITS-1:0]    datD_q [NSAMP];
   logic signed [SUM_BITS-1:0]    sum_q  [NSAMP];
   logic signed [SUM_BITS-1:0]    sum_d  [NSAMP];
   logic signed [PROD_BITS-1:0]   prod_q [NSAMP];
   logic signed [PROD_BITS-1:0]   prod_d [NSAMP];
   logic signed [PROD_BITS-1:0]   prodP_q [NSAMP];
   logic signed [PROD_BITS-1:0]   qv;
   logic [NBITS-1:0]              ov, ovNeg;

   logic [NSAMP*NBITS-1:0]     out_q, out_d;
   logic [NSAMP*(NBITS-1)-1:0] abs_q, abs_d;
   logic [NSAMP-1:0]           gt_q, gt_d, lt_q, lt_d;

   logic [CNT_BITS-1:0] accHi_q, accLo_q, accHi_d, accLo_d, satHi_q, satLo_q;
   logic [CNT_BITS:0]   hiSum, loSum;
   logic                cntValid_q;

   assign winEnd = &winCnt_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) state_q <= IDLE;
      else         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (apply_i) state_d = PENDING;
         PENDING: if (winEnd) state_d = COMMIT;
         COMMIT:  state_d = apply_i ? PENDING : IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      apply_pending_o = (state_q == PENDING);
      apply_done_o    = (state_q == COMMIT);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scaleStg_q  <= UNITY;
         scaleAct_q  <= UNITY;
         offsetStg_q <= '0;
         offsetAct_q <= '0;
         winCnt_q    <= '0;
      end else begin
         winCnt_q <= winCnt_q + WINDOW_LOG2'(1);
         if (ce_scale_i)  scaleStg_q  <= scale_i;
         if (ce_offset_i) offsetStg_q <= offset_i;
         if (state_q == COMMIT) begin
            scaleAct_q  <= scaleStg_q;
            offsetAct_q <= offsetStg_q;
         end
      end
   end

   // Settings travel down the pipe with their data so a commit never splits a sample.
   always_comb begin
      for (int k = 0; k < NSAMP; k++) begin
         sum_d[k]  = (SUM_BITS'(datD_q[k]) <<< DSH) + (SUM_BITS'(offsetD_q) <<< OSH);
         prod_d[k] = PROD_BITS'(sum_q[k]) * PROD_BITS'($signed({1'b0, scaleA_q}));
      end
   end

   always_comb begin
      out_d = '0;
      abs_d = '0;
      gt_d  = '0;
      lt_d  = '0;
      qv    = '0;
      ov    = '0;
      ovNeg = '0;
      for (int k = 0; k < NSAMP; k++) begin
         qv = prodP_q[k] >>> LSB;
         if (qv > QMAX) begin
            ov = QMAX[NBITS-1:0];
            gt_d[k] = 1'b1;
         end else if (qv < QMIN) begin
            ov = QMIN[NBITS-1:0];
            lt_d[k] = 1'b1;
         end else begin
            ov = qv[NBITS-1:0];
         end
         ovNeg = '0 - ov;
         out_d[k*NBITS +: NBITS] = ov;
         if (!ov[NBITS-1])      abs_d[k*(NBITS-1) +: NBITS-1] = ov[NBITS-2:0];
         else if (ov == MINOUT) abs_d[k*(NBITS-1) +: NBITS-1] = MAXABS;
         else                   abs_d[k*(NBITS-1) +: NBITS-1] = ovNeg[NBITS-2:0];
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         scaleD_q  <= '0;
         offsetD_q <= '0;
         scaleA_q  <= '0;
         for (int k = 0; k < NSAMP; k++) begin
            datD_q[k]  <= '0;
            sum_q[k]   <= '0;
            prod_q[k]  <= '0;
            prodP_q[k] <= '0;
         end
         out_q <= '0;
         abs_q <= '0;
         gt_q  <= '0;
         lt_q  <= '0;
      end else begin
         scaleD_q  <= scaleAct_q;
         offsetD_q <= offsetAct_q;
         scaleA_q  <= scaleD_q;
         for (int k = 0; k < NSAMP; k++) begin
            datD_q[k]  <= dat_i[k*DAT_BITS +: DAT_BITS];
            sum_q[k]   <= sum_d[k];
            prod_q[k]  <= prod_d[k];
            prodP_q[k] <= prod_q[k] + ROUND_C;
         end
         out_q <= out_d;
         abs_q <= abs_d;
         gt_q  <= gt_d;
         lt_q  <= lt_d;
      end
   end

   always_comb begin
      hiSum   = {1'b0, accHi_q} + (CNT_BITS+1)'($countones(gt_q));
      loSum   = {1'b0, accLo_q} + (CNT_BITS+1)'($countones(lt_q));
      accHi_d = hiSum[CNT_BITS] ? '1 : hiSum[CNT_BITS-1:0];
      accLo_d = loSum[CNT_BITS] ? '1 : loSum[CNT_BITS-1:0];
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         accHi_q    <= '0;
         accLo_q    <= '0;
         satHi_q    <= '0;
         satLo_q    <= '0;
         cntValid_q <= 1'b0;
      end else begin
         cntValid_q <= winEnd;
         if (winEnd) begin
            satHi_q <= accHi_d;
            satLo_q <= accLo_d;
            accHi_q <= '0;
            accLo_q <= '0;
         end else begin
            accHi_q <= accHi_d;
            accLo_q <= accLo_d;
         end
      end
   end

   assign out_o        = out_q;
   assign abs_o        = abs_q;
   assign gt_o         = gt_q;
   assign lt_o         = lt_q;
   assign sat_hi_cnt_o = satHi_q;
   assign sat_lo_cnt_o = satLo_q;
   assign cnt_valid_o  = cntValid_q;
endmodule

// File: tb/tb_agc_dsp_multi.sv
// Self-checking bench for agc_dsp_multi: directed steps plus random traffic compared
// against a cycle-level reference model built from the arithmetic and apply rules.
module tb_agc_dsp_multi;
   localparam int NSAMP       = 8;
   localparam int DAT_BITS    = 12;
   localparam int OFFSET_BITS = 12;
   localparam int NBITS       = 5;
   localparam int WINDOW_LOG2 = 4;
   localparam int CNT_BITS    = 7;
   localparam int WIN         = 1 << WINDOW_LOG2;
   localparam int CNT_MAX     = (1 << CNT_BITS) - 1;
   localparam int Q_SUM_TB    = 8;
   localparam int LSB_TB      = Q_SUM_TB + 12 + 5 - 2;
   localparam int OUT_MAX     = 15;
   localparam int OUT_MIN     = -16;
   localparam int UNITY       = 4096;

   typedef logic [NSAMP*DAT_BITS-1:0] lanes_t;

   typedef struct packed {
      logic [NSAMP*NBITS-1:0]     out;
      logic [NSAMP*(NBITS-1)-1:0] absv;
      logic [NSAMP-1:0]           gt;
      logic [NSAMP-1:0]           lt;
   } laneRes_t;

   logic                        clk_i = 1'b0;
   logic                        rst_ni = 1'b0;
   lanes_t                      dat_i = '0;
   logic [16:0]                 scale_i = '0;
   logic [OFFSET_BITS-1:0]      offset_i = '0;
   logic                        ce_scale_i = 1'b0;
   logic                        ce_offset_i = 1'b0;
   logic                        apply_i = 1'b0;
   logic [NSAMP*NBITS-1:0]      out_o;
   logic [NSAMP*(NBITS-1)-1:0]  abs_o;
   logic [NSAMP-1:0]            gt_o, lt_o;
   logic                        apply_pending_o, apply_done_o, cnt_valid_o;
   logic [CNT_BITS-1:0]         sat_hi_cnt_o, sat_lo_cnt_o;

   int checks = 0;
   int errors = 0;

   // Reference model state
   int       cycle;
   longint   actScale, actOffset, stgScale, stgOffset;
   logic     mPending, mCommit;
   int       accHi, accLo, latchHi, latchLo;
   laneRes_t pipeQ[$];

   agc_dsp_multi #(.WINDOW_LOG2(WINDOW_LOG2), .CNT_BITS(CNT_BITS)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .dat_i(dat_i), .scale_i(scale_i),
      .offset_i(offset_i), .ce_scale_i(ce_scale_i), .ce_offset_i(ce_offset_i),
      .apply_i(apply_i), .out_o(out_o), .abs_o(abs_o), .gt_o(gt_o), .lt_o(lt_o),
      .apply_pending_o(apply_pending_o), .apply_done_o(apply_done_o),
      .sat_hi_cnt_o(sat_hi_cnt_o), .sat_lo_cnt_o(sat_lo_cnt_o), .cnt_valid_o(cnt_valid_o)
   );

   always #5 clk_i = ~clk_i;

   // Expected lane results straight from (dat + offset) * scale, floored and saturated
   function automatic laneRes_t calcLanes(input lanes_t dat, input longint scale, input longint offset);
      laneRes_t r;
      longint d, prod, q, o, a, div;
      logic [DAT_BITS-1:0] raw;
      logic [NBITS-1:0] o5;
      logic [NBITS-2:0] a4;
      r = '0;
      div = longint'(1) << LSB_TB;
      for (int k = 0; k < NSAMP; k++) begin
         raw  = dat[k*DAT_BITS +: DAT_BITS];
         d    = longint'($signed(raw));
         prod = (d * (longint'(1) << Q_SUM_TB) + offset) * scale;
`ifdef AGC_DSP_MULTI_ROUND_EN
         prod = prod + div / 2;
`endif
         q = prod / div;
         if (prod < 0 && q * div != prod) q = q - 1;
         if (q > OUT_MAX) begin
            o = OUT_MAX;
            r.gt[k] = 1'b1;
         end else if (q < OUT_MIN) begin
            o = OUT_MIN;
            r.lt[k] = 1'b1;
         end else begin
            o = q;
         end
         a = (o < 0) ? -o : o;
         if (a > OUT_MAX) a = OUT_MAX;
         o5 = NBITS'(o);
         a4 = (NBITS-1)'(a);
         r.out[k*NBITS +: NBITS] = o5;
         r.absv[k*(NBITS-1) +: NBITS-1] = a4;
      end
      return r;
   endfunction

   function automatic lanes_t allLanes(input int v);
      lanes_t r;
      for (int k = 0; k < NSAMP; k++) r[k*DAT_BITS +: DAT_BITS] = DAT_BITS'(v);
      return r;
   endfunction

   function automatic lanes_t setLane(input lanes_t d, input int k, input int v);
      lanes_t r;
      r = d;
      r[k*DAT_BITS +: DAT_BITS] = DAT_BITS'(v);
      return r;
   endfunction

   // Mostly near-RMS samples with an occasional full-scale one
   function automatic lanes_t randLanes();
      lanes_t r;
      for (int k = 0; k < NSAMP; k++) begin
         if ($urandom_range(0, 3) == 0) r[k*DAT_BITS +: DAT_BITS] = DAT_BITS'($urandom);
         else r[k*DAT_BITS +: DAT_BITS] = DAT_BITS'(int'($urandom_range(0, 320)) - 160);
      end
      return r;
   endfunction

   task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic checkAllZero(input string tag);
      checkOutput({tag, "_out"}, 64'(out_o), 64'(0));
      checkOutput({tag, "_abs"}, 64'(abs_o), 64'(0));
      checkOutput({tag, "_gtlt"}, 64'({gt_o, lt_o}), 64'(0));
      checkOutput({tag, "_ctrl"}, 64'({apply_pending_o, apply_done_o, cnt_valid_o}), 64'(0));
      checkOutput({tag, "_cnts"}, 64'({sat_hi_cnt_o, sat_lo_cnt_o}), 64'(0));
   endtask

   // Reset the DUT (asynchronously) and the model together; release just after a rising edge
   task automatic doReset();
      rst_ni = 1'b0;
      dat_i = '0; ce_scale_i = 1'b0; ce_offset_i = 1'b0; apply_i = 1'b0;
      #1;
      checkAllZero("reset_async");
      repeat (2) @(posedge clk_i);
      #1;
      checkAllZero("reset_held");
      rst_ni = 1'b1;
      cycle = 0;
      actScale = UNITY; stgScale = UNITY;
      actOffset = 0;    stgOffset = 0;
      mPending = 1'b0;  mCommit = 1'b0;
      accHi = 0; accLo = 0; latchHi = 0; latchLo = 0;
      pipeQ.delete();
      repeat (5) pipeQ.push_back('0);
   endtask

   // One clock cycle: check this cycle's outputs, drive this cycle's inputs, advance the model
   task automatic applyStimulus(input lanes_t dat, input logic ceS, input logic [16:0] sVal,
                                input logic ceO, input logic [OFFSET_BITS-1:0] oVal,
                                input logic apply);
      laneRes_t exp;
      logic validExp;
      exp = pipeQ.pop_front();
      validExp = (cycle > 0) && (cycle % WIN == 0);
      checkOutput("out_o", 64'(out_o), 64'(exp.out));
      checkOutput("abs_o", 64'(abs_o), 64'(exp.absv));
      checkOutput("gt_o", 64'(gt_o), 64'(exp.gt));
      checkOutput("lt_o", 64'(lt_o), 64'(exp.lt));
      checkOutput("apply_pending_o", 64'(apply_pending_o), 64'(mPending));
      checkOutput("apply_done_o", 64'(apply_done_o), 64'(mCommit));
      checkOutput("cnt_valid_o", 64'(cnt_valid_o), 64'(validExp));
      checkOutput("sat_hi_cnt_o", 64'(sat_hi_cnt_o), 64'(latchHi));
      checkOutput("sat_lo_cnt_o", 64'(sat_lo_cnt_o), 64'(latchLo));

      dat_i = dat; ce_scale_i = ceS; scale_i = sVal;
      ce_offset_i = ceO; offset_i = oVal; apply_i = apply;

      pipeQ.push_back(calcLanes(dat, actScale, actOffset));
      accHi = accHi + $countones(exp.gt);
      accLo = accLo + $countones(exp.lt);
      if (accHi > CNT_MAX) accHi = CNT_MAX;
      if (accLo > CNT_MAX) accLo = CNT_MAX;
      if (cycle % WIN == WIN - 1) begin
         latchHi = accHi; latchLo = accLo;
         accHi = 0; accLo = 0;
      end
      if (mCommit) begin
         actScale = stgScale; actOffset = stgOffset;
         mCommit = 1'b0; mPending = apply;
      end else if (mPending) begin
         if (cycle % WIN == WIN - 1) begin
            mPending = 1'b0; mCommit = 1'b1;
         end
      end else if (apply) begin
         mPending = 1'b1;
      end
      if (ceS) stgScale = longint'(sVal);
      if (ceO) stgOffset = longint'($signed(oVal));
      cycle++;
      @(posedge clk_i);
      #1;
   endtask

   task automatic holdData(input lanes_t dat, input int n);
      for (int i = 0; i < n; i++) applyStimulus(dat, 1'b0, '0, 1'b0, '0, 1'b0);
   endtask

   // Directed steps followed by randomized traffic
   initial begin
      lanes_t d;
      logic ceS, ceO, ap;
      doReset();
      holdData(allLanes(0), 3);
      holdData(allLanes(32), 1);
      holdData(allLanes(-32), 1);
      d = setLane(setLane(allLanes(0), 3, 100), 5, -100);
      holdData(d, 1);
      d = setLane(setLane(allLanes(0), 3, 2000), 5, -2000);
      holdData(d, 1);
      for (int k = 0; k < NSAMP; k++) d = setLane(d, k, (k % 2 == 0) ? 33 : -33);
      holdData(d, 1);
      holdData(allLanes(2047), 1);
      holdData(allLanes(-2048), 1);
      holdData(allLanes(0), 6);

      $display("[TB] window counters");
      d = setLane(setLane(randLanes(), 0, 2047), 1, -2048);
      holdData(d, 3 * WIN);
      holdData(allLanes(2047), 2 * WIN + 6);

      $display("[TB] staged apply at window end");
      while (cycle % WIN != 5) holdData(allLanes(31), 1);
      applyStimulus(allLanes(31), 1'b1, 17'd8192, 1'b1, 12'd256, 1'b0);
      applyStimulus(allLanes(31), 1'b0, '0, 1'b0, '0, 1'b1);
      holdData(allLanes(31), 2 * WIN);
      checkOutput("apply_out31_lane0", 64'(out_o[NBITS-1:0]), 64'(8));

      $display("[TB] second apply during pending");
      applyStimulus(allLanes(31), 1'b0, '0, 1'b0, '0, 1'b1);
      applyStimulus(allLanes(31), 1'b1, 17'd2048, 1'b0, '0, 1'b1);
      holdData(allLanes(31), 2 * WIN);
      checkOutput("apply2_out31_lane0", 64'(out_o[NBITS-1:0]), 64'(2));

      $display("[TB] reset while pending");
      while (cycle % WIN != 3) holdData(allLanes(31), 1);
      applyStimulus(allLanes(31), 1'b0, '0, 1'b0, '0, 1'b1);
      applyStimulus(allLanes(31), 1'b1, 17'd12345, 1'b0, '0, 1'b0);
      holdData(allLanes(31), 3);
      doReset();
      holdData(allLanes(32), 2 * WIN);
      checkOutput("post_reset_out32_lane0", 64'(out_o[NBITS-1:0]), 64'(4));

      $display("[TB] random traffic");
      for (int i = 0; i < 300; i++) begin
         ceS = ($urandom_range(0, 7) == 0);
         ceO = ($urandom_range(0, 7) == 0);
         ap  = ($urandom_range(0, 9) == 0);
         applyStimulus(randLanes(), ceS, 17'($urandom_range(0, 12000)), ceO,
                       OFFSET_BITS'($urandom), ap);
      end
      holdData(allLanes(0), WIN + 6);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
